// File: rtl/turn_scheduler.sv
// Two-player turn controller for the shared 1..26 selection counter: grants the
// counter to one player at a time, enforces the turn time limit and reports the winner.
module turn_scheduler #(
  parameter int TURN_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       p1_req,
  input  logic       p2_req,
  input  logic       p1_done,
  input  logic       p2_done,
  input  logic [4:0] count_in,
  output logic       cnt_enable,
  output logic       cnt_signal,
  output logic       cnt_rst,
  output logic [1:0] active_player,
  output logic [4:0] p1_sel,
  output logic [4:0] p2_sel,
  output logic       p1_to,
  output logic       p2_to,
  output logic [1:0] winner,
  output logic       game_over
);

  localparam int TW = $clog2(TURN_CYCLES);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TURN_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    P1_TURN,
    P1_LOCK,
    P2_TURN,
    P2_LOCK,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            cnt_signal_q, cnt_signal_d;
  logic [4:0]      p1_sel_q, p1_sel_d;
  logic [4:0]      p2_sel_q, p2_sel_d;
  logic            p1_to_q, p1_to_d;
  logic            p2_to_q, p2_to_d;
  logic [1:0]      winner_q, winner_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      cnt_signal_q <= 1'b0;
      p1_sel_q     <= '0;
      p2_sel_q     <= '0;
      p1_to_q      <= 1'b0;
      p2_to_q      <= 1'b0;
      winner_q     <= 2'b00;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      cnt_signal_q <= cnt_signal_d;
      p1_sel_q     <= p1_sel_d;
      p2_sel_q     <= p2_sel_d;
      p1_to_q      <= p1_to_d;
      p2_to_q      <= p2_to_d;
      winner_q     <= winner_d;
    end
  end

  // A step strobe is only produced while the turn continues; the edge that
  // leaves the turn (done or timeout) never issues one, so LOCK sees it low.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    cnt_signal_d = 1'b0;
    p1_sel_d     = p1_sel_q;
    p2_sel_d     = p2_sel_q;
    p1_to_d      = p1_to_q;
    p2_to_d      = p2_to_q;
    winner_d     = winner_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = P1_TURN;
          timer_d  = TIMER_LOAD;
          p1_sel_d = '0;
          p2_sel_d = '0;
          p1_to_d  = 1'b0;
          p2_to_d  = 1'b0;
          winner_d = 2'b00;
        end
      end
      P1_TURN: begin
        if (p1_done) begin
          state_d = P1_LOCK;
        end else if (timer_q == '0) begin
          state_d = P1_LOCK;
          p1_to_d = 1'b1;
        end else begin
          timer_d      = timer_q - TW'(1);
          cnt_signal_d = p1_req;
        end
      end
      P1_LOCK: begin
        p1_sel_d = count_in;
        state_d  = P2_TURN;
        timer_d  = TIMER_LOAD;
      end
      P2_TURN: begin
        if (p2_done) begin
          state_d = P2_LOCK;
        end else if (timer_q == '0) begin
          state_d = P2_LOCK;
          p2_to_d = 1'b1;
        end else begin
          timer_d      = timer_q - TW'(1);
          cnt_signal_d = p2_req;
        end
      end
      P2_LOCK: begin
        // p2_sel is captured on this same edge, so compare against count_in directly.
        p2_sel_d = count_in;
        state_d  = DONE;
        if (p1_sel_q > count_in) begin
          winner_d = 2'b01;
        end else if (p1_sel_q < count_in) begin
          winner_d = 2'b10;
        end else begin
          winner_d = 2'b11;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    cnt_enable    = 1'b0;
    cnt_rst       = 1'b0;
    active_player = 2'b00;
    game_over     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_rst = 1'b1;
      end
      P1_TURN: begin
        cnt_enable    = 1'b1;
        active_player = 2'b01;
      end
      P1_LOCK: begin
        cnt_rst       = 1'b1;
        active_player = 2'b01;
      end
      P2_TURN: begin
        cnt_enable    = 1'b1;
        active_player = 2'b10;
      end
      P2_LOCK: begin
        cnt_rst       = 1'b1;
        active_player = 2'b10;
      end
      DONE: begin
        cnt_rst   = 1'b1;
        game_over = 1'b1;
      end
      default: begin
        cnt_rst = 1'b1;
      end
    endcase
  end

  assign cnt_signal = cnt_signal_q;
  assign p1_sel     = p1_sel_q;
  assign p2_sel     = p2_sel_q;
  assign p1_to      = p1_to_q;
  assign p2_to      = p2_to_q;
  assign winner     = winner_q;

endmodule
